// File: rtl/approx_add_pkg.sv
// Shared definitions for the LOA approximate adder: k clamping and a
// width-generic combinational golden model of the approximate sum.
package approx_add_pkg;

    localparam int unsigned APPROX_MAX_DFLT = 4;
    localparam int unsigned K_W             = $clog2(APPROX_MAX_DFLT + 1);
    localparam int unsigned MODEL_W         = 64;

    function automatic int unsigned k_clamp(input int unsigned k, input int unsigned approx_max);
        return (k > approx_max) ? approx_max : k;
    endfunction

    // Operands are zero-extended into MODEL_W bits; the result is exact for any WIDTH < MODEL_W.
    function automatic logic [MODEL_W:0] loa_sum(input logic [MODEL_W-1:0] a,
                                                 input logic [MODEL_W-1:0] b,
                                                 input int unsigned       k);
        logic [MODEL_W:0] lo;
        logic [MODEL_W:0] up;
        logic [MODEL_W:0] c;
        lo = {1'b0, (a | b) & ~({MODEL_W{1'b1}} << k)};
        c  = '0;
        if (k != 0) c[0] = ((a & b) >> (k - 1)) & 1;
        up = ({1'b0, a >> k} + {1'b0, b >> k} + c) << k;
        return up | lo;
    endfunction

endpackage

// File: rtl/approx_err_stats.sv
// Running error statistics on the result stream: saturating sample and
// error counters plus a max-error tracker, with clear folding in a coincident beat.
module approx_err_stats #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              clr,
    input  logic [DATA_W-1:0] err,
    output logic [STAT_W-1:0] err_cnt,
    output logic [DATA_W-1:0] err_max,
    output logic [STAT_W-1:0] samples
);

    logic err_nz;

    assign err_nz = (err != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
            err_max <= '0;
            samples <= '0;
        end else if (clr) begin
            // A beat completing on the clear cycle becomes the first sample.
            err_cnt <= hs ? STAT_W'(err_nz) : '0;
            err_max <= hs ? err : '0;
            samples <= hs ? STAT_W'(1) : '0;
        end else if (hs) begin
            if (samples != '1) samples <= samples + 1'b1;
            if (err_nz && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            if (err > err_max) err_max <= err;
        end
    end

endmodule

// File: rtl/approx_loa_add_pipe.sv
// Two-stage pipelined lower-part-OR approximate adder with run-time k,
// exact reference, per-beat absolute error and on-chip error statistics.
module approx_loa_add_pipe
    import approx_add_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned APPROX_MAX = 4,
    parameter  int unsigned STAT_W     = 16,
    localparam int unsigned K_BITS     = $clog2(APPROX_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [K_BITS-1:0] in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_sum,
    output logic [WIDTH:0]    out_err,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_err_cnt,
    output logic [WIDTH:0]    stat_err_max,
    output logic [STAT_W-1:0] stat_samples
);

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_lo_or;
    logic [WIDTH-1:0]  s1_ua;
    logic [WIDTH-1:0]  s1_ub;
    logic              s1_c;
    logic [K_BITS-1:0] s1_keff;
    logic [WIDTH:0]    s1_exact;

    logic              s2_advance;
    logic [31:0]       keff_in;
    logic [31:0]       s1_keff_w;
    logic [WIDTH-1:0]  lo_mask;
    logic [WIDTH-1:0]  ab_and;
    logic              c_in;
    logic [WIDTH:0]    up_sum;
    logic [WIDTH:0]    approx;
    logic [WIDTH:0]    abs_err;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    assign keff_in = k_clamp(32'(in_k), APPROX_MAX);
    assign lo_mask = ~({WIDTH{1'b1}} << keff_in);
    assign ab_and  = in_a & in_b;

    // Carry into the exact part comes from the top approximated bit.
    always_comb begin
        c_in = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i + 1 == keff_in) c_in = ab_and[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo_or <= (in_a | in_b) & lo_mask;
                s1_c     <= c_in;
                s1_ua    <= in_a >> keff_in;
                s1_ub    <= in_b >> keff_in;
                s1_keff  <= K_BITS'(keff_in);
                s1_exact <= {1'b0, in_a} + {1'b0, in_b};
            end
        end
    end

    assign s1_keff_w = 32'(s1_keff);

    always_comb begin
        up_sum  = {1'b0, s1_ua} + {1'b0, s1_ub} + (WIDTH + 1)'(s1_c);
        approx  = (up_sum << s1_keff_w) | {1'b0, s1_lo_or};
        abs_err = (s1_exact >= approx) ? (s1_exact - approx) : (approx - s1_exact);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= '0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= approx;
                out_err <= abs_err;
            end
        end
    end

    approx_err_stats #(
        .DATA_W (WIDTH + 1),
        .STAT_W (STAT_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .hs      (out_valid && out_ready),
        .clr     (stat_clr),
        .err     (out_err),
        .err_cnt (stat_err_cnt),
        .err_max (stat_err_max),
        .samples (stat_samples)
    );

endmodule

// File: tb/tb_approx_loa_add_pipe.sv
// Directed bench for approx_loa_add_pipe: vector table plus hand-written
// latency, back-to-back, backpressure, stats-clear and reset sequences.
module tb_approx_loa_add_pipe;
    import approx_add_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [2:0]  in_k;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_sum;
    logic [8:0]  out_err;
    logic        stat_clr;
    logic [15:0] stat_err_cnt;
    logic [8:0]  stat_err_max;
    logic [15:0] stat_samples;

    logic        in_ready2;
    logic        out_valid2;
    logic [8:0]  out_sum2;
    logic [8:0]  out_err2;
    logic [1:0]  stat_err_cnt2;
    logic [8:0]  stat_err_max2;
    logic [1:0]  stat_samples2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] k;
        logic [8:0] sum;
        logic [8:0] err;
    } vec_t;

    vec_t tbl[10];
    vec_t bb[4];
    vec_t bp[3];

    always #5 clk = ~clk;

    approx_loa_add_pipe #(.WIDTH(8), .APPROX_MAX(4), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
        .stat_clr(stat_clr), .stat_err_cnt(stat_err_cnt), .stat_err_max(stat_err_max),
        .stat_samples(stat_samples)
    );

    approx_loa_add_pipe #(.WIDTH(8), .APPROX_MAX(4), .STAT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_k(in_k),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_err(out_err2),
        .stat_clr(stat_clr), .stat_err_cnt(stat_err_cnt2), .stat_err_max(stat_err_max2),
        .stat_samples(stat_samples2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_a = v.a;
        in_b = v.b;
        in_k = v.k;
    endtask

    task automatic chk_stats(input string tag, input int smp, input int cnt, input int mx);
        chk({tag, " samples"}, 32'(stat_samples), 32'(smp));
        chk({tag, " err_cnt"}, 32'(stat_err_cnt), 32'(cnt));
        chk({tag, " err_max"}, 32'(stat_err_max), 32'(mx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int n_rx;
        bit take;
        logic [8:0] rx_sum[3];
        logic [8:0] rx_err[3];

        tbl[0] = '{8'd200, 8'd100, 3'd0, 9'd300, 9'd0};
        tbl[1] = '{8'h07,  8'h01,  3'd3, 9'd7,   9'd1};
        tbl[2] = '{8'h0F,  8'h0F,  3'd4, 9'd31,  9'd1};
        tbl[3] = '{8'h0F,  8'h0F,  3'd7, 9'd31,  9'd1};
        tbl[4] = '{8'd1,   8'd1,   3'd1, 9'd3,   9'd1};
        tbl[5] = '{8'hAA,  8'h55,  3'd2, 9'd255, 9'd0};
        tbl[6] = '{8'hFF,  8'hFF,  3'd4, 9'd511, 9'd1};
        tbl[7] = '{8'h08,  8'h08,  3'd4, 9'd24,  9'd8};
        tbl[8] = '{8'h03,  8'h05,  3'd3, 9'd7,   9'd1};
        tbl[9] = '{8'd255, 8'd255, 3'd0, 9'd510, 9'd0};

        bb[0] = '{8'd1,   8'd1,   3'd1, 9'd3,   9'd1};
        bb[1] = '{8'd2,   8'd2,   3'd1, 9'd4,   9'd0};
        bb[2] = '{8'd255, 8'd255, 3'd1, 9'd511, 9'd1};
        bb[3] = '{8'd0,   8'd0,   3'd0, 9'd0,   9'd0};

        bp[0] = '{8'd5,   8'd9,   3'd0, 9'd14,  9'd0};
        bp[1] = '{8'h0F,  8'h0F,  3'd4, 9'd31,  9'd1};
        bp[2] = '{8'd200, 8'd100, 3'd0, 9'd300, 9'd0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_k = '0;
        out_ready = 1'b1; stat_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_sum", 32'(out_sum), 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk_stats("rst", 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            chk($sformatf("model[%0d]", i),
                32'(loa_sum(64'(tbl[i].a), 64'(tbl[i].b), k_clamp(32'(tbl[i].k), 4))),
                32'(tbl[i].sum));
            drive(tbl[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("lat1 valid[%0d]", i), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("lat2 valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("sum[%0d]", i), 32'(out_sum), 32'(tbl[i].sum));
            chk($sformatf("err[%0d]", i), 32'(out_err), 32'(tbl[i].err));
            tick();
        end
        chk_stats("table", 10, 7, 8);
        chk("sat samples", 32'(stat_samples2), 32'd3);
        chk("sat err_cnt", 32'(stat_err_cnt2), 32'd3);
        chk("sat err_max", 32'(stat_err_max2), 32'd8);

        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk_stats("clr idle", 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive(bb[i]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (i < 4) chk($sformatf("bb in_ready[%0d]", i), 32'(in_ready), 32'd1);
            tick();
            if (i >= 1) begin
                chk($sformatf("bb valid[%0d]", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("bb sum[%0d]", i - 1), 32'(out_sum), 32'(bb[i - 1].sum));
                chk($sformatf("bb err[%0d]", i - 1), 32'(out_err), 32'(bb[i - 1].err));
            end
        end
        tick();
        chk("bb drained", 32'(out_valid), 32'd0);
        chk_stats("bb", 4, 2, 1);

        drive(bb[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk_stats("clr+hs", 1, 1, 1);

        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 3);
            if (idx < 3) drive(bp[idx]);
            take = in_valid && in_ready;
            tick();
            if (take) idx++;
            if (cyc >= 1) begin
                chk($sformatf("bp hold valid[%0d]", cyc), 32'(out_valid), 32'd1);
                chk($sformatf("bp hold sum[%0d]", cyc), 32'(out_sum), 32'(bp[0].sum));
            end
        end
        chk("bp accepted", 32'(idx), 32'd2);
        chk("bp in_ready", 32'(in_ready), 32'd0);

        out_ready = 1'b1;
        n_rx = 0;
        for (int cyc = 0; cyc < 20 && n_rx < 3; cyc++) begin
            if (out_valid) begin
                rx_sum[n_rx] = out_sum;
                rx_err[n_rx] = out_err;
                n_rx++;
            end
            in_valid = (idx < 3);
            if (idx < 3) drive(bp[idx]);
            take = in_valid && in_ready;
            tick();
            if (take) idx++;
        end
        in_valid = 1'b0;
        chk("bp delivered", 32'(n_rx), 32'd3);
        for (int i = 0; i < 3 && i < n_rx; i++) begin
            chk($sformatf("bp sum[%0d]", i), 32'(rx_sum[i]), 32'(bp[i].sum));
            chk($sformatf("bp err[%0d]", i), 32'(rx_err[i]), 32'(bp[i].err));
        end
        tick();
        chk("bp no dup", 32'(out_valid), 32'd0);

        drive(bb[0]);
        in_valid = 1'b1;
        tick();
        drive(bb[1]);
        tick();
        chk("pre-rst valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-rst out_valid", 32'(out_valid), 32'd0);
        chk("mid-rst out_sum", 32'(out_sum), 32'd0);
        chk("mid-rst in_ready", 32'(in_ready), 32'd1);
        chk_stats("mid-rst", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flushed[%0d]", i), 32'(out_valid), 32'd0);
        end

        drive(tbl[0]);
        in_valid = 1'b1;
        chk("resume in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("resume valid", 32'(out_valid), 32'd1);
        chk("resume sum", 32'(out_sum), 32'(tbl[0].sum));
        tick();
        chk_stats("resume", 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
